// File: rtl/fetch_pkg.sv
// Shared encodings and default sizes for the instruction fetch sequencer.
package fetch_pkg;

   localparam int unsigned ADDR_W_DEF   = 10;
   localparam int unsigned DATA_W_DEF   = 32;
   localparam int unsigned RESET_PC_DEF = 0;

   // Encoding is visible on state_out, so the values are fixed.
   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_slot.sv
// One-entry output register holding the fetched instruction and its index.
// Flush wins over load; with neither asserted the entry holds.
module fetch_slot
   import fetch_pkg::*;
#(
   parameter int unsigned AW = ADDR_W_DEF,
   parameter int unsigned DW = DATA_W_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          load_i,
   input  logic [DW-1:0] data_i,
   input  logic [AW-1:0] pc_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   output logic [AW-1:0] pc_o
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   logic [AW-1:0] pc_q, pc_d;

   // Next-entry selection: flush clears only the valid bit, load captures.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      pc_d    = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         pc_d    = pc_i;
      end
   end

   // Entry register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: boot-loads the instruction memory, then
// streams one instruction per cycle to decode with redirect and halt.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_LOAD | accepting boot words, writing them straight into memory
// ST_RUN  | fetching at pc into the output slot, one per cycle
// ST_HALT | fetch stopped, pc holds next index, redirects still land
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned RESET_PC  = RESET_PC_DEF,
   parameter bit          BOOT_LOAD = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid_i,
   output logic              load_ready_o,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic              load_last_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_waddr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [ADDR_W-1:0] pc_out_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              insn_valid_o,
   input  logic              insn_ready_i,
   output logic [DATA_W-1:0] insn_o,
   output logic [ADDR_W-1:0] insn_pc_o,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   input  logic              halt_req_i,
   input  logic              resume_i,
   output logic [1:0]        state_out_o,
   output logic              wrap_flag_o
);

   localparam logic [ADDR_W-1:0] START_PC  = ADDR_W'(RESET_PC);
   localparam fetch_state_e      RST_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              wrap_q, wrap_d;
   logic              slot_flush, slot_load, slot_valid;
   logic              fe;
   logic              in_load;

   assign fe = !slot_valid || insn_ready_i;

   // Held low during reset so the boot handshake never acks while the
   // sequencer is still being cleared.
   assign in_load = (state_q == ST_LOAD) && rst_n;

   // Next-state, pc and slot control.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      wrap_d       = wrap_q;
      slot_flush   = 1'b0;
      slot_load    = 1'b0;
      load_ready_o = 1'b0;
      mem_we_o     = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            load_ready_o = in_load;
            if (in_load && load_valid_i) begin
               mem_we_o = 1'b1;
               if (load_last_i) begin
                  state_d = ST_RUN;
                  pc_d    = START_PC;
               end
            end
         end
         ST_RUN: begin
            if (redirect_valid_i) begin
               pc_d       = redirect_pc_i;
               slot_flush = 1'b1;
            end else if (halt_req_i) begin
               state_d    = ST_HALT;
               slot_flush = 1'b1;
            end else if (fe) begin
               slot_load = 1'b1;
               pc_d      = pc_q + 1'b1;
               if (pc_q == '1) wrap_d = 1'b1;
            end
         end
         ST_HALT: begin
            if (redirect_valid_i) pc_d = redirect_pc_i;
            if (resume_i && !halt_req_i) state_d = ST_RUN;
         end
         default: begin
            state_d    = RST_STATE;
            slot_flush = 1'b1;
         end
      endcase
   end

   // State, pc and sticky wrap registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
         pc_q    <= START_PC;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wrap_q  <= wrap_d;
      end
   end

   fetch_slot #(
      .AW (ADDR_W),
      .DW (DATA_W)
   ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (slot_flush),
      .load_i  (slot_load),
      .data_i  (mem_rdata_i),
      .pc_i    (pc_q),
      .valid_o (slot_valid),
      .data_o  (insn_o),
      .pc_o    (insn_pc_o)
   );

   assign mem_waddr_o  = load_addr_i;
   assign mem_wdata_o  = load_data_i;
   assign pc_out_o     = pc_q;
   assign insn_valid_o = slot_valid;
   assign state_out_o  = state_q;
   assign wrap_flag_o  = wrap_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot load, streaming, backpressure,
// redirect, halt/resume, pc wrap and asynchronous reset.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid, load_ready, load_last;
   logic [9:0]  load_addr;
   logic [31:0] load_data;
   logic        mem_we;
   logic [9:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic [9:0]  pc_out;
   logic [31:0] mem_rdata;
   logic        insn_valid, insn_ready;
   logic [31:0] insn;
   logic [9:0]  insn_pc;
   logic        redirect_valid;
   logic [9:0]  redirect_pc;
   logic        halt_req, resume;
   logic [1:0]  state_out;
   logic        wrap_flag;

   int n_tests = 0;
   int n_fail  = 0;

   // Memory model: untouched words read as C0DE_xxxx, boot words as written.
   logic [31:0] mem [1024];
   bit          wr_ok [1024];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr]   <= mem_wdata;
         wr_ok[mem_waddr] <= 1'b1;
      end
   end

   assign mem_rdata = wr_ok[pc_out] ? mem[pc_out] : (32'hC0DE_0000 | 32'(pc_out));

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .load_valid_i     (load_valid),
      .load_ready_o     (load_ready),
      .load_addr_i      (load_addr),
      .load_data_i      (load_data),
      .load_last_i      (load_last),
      .mem_we_o         (mem_we),
      .mem_waddr_o      (mem_waddr),
      .mem_wdata_o      (mem_wdata),
      .pc_out_o         (pc_out),
      .mem_rdata_i      (mem_rdata),
      .insn_valid_o     (insn_valid),
      .insn_ready_i     (insn_ready),
      .insn_o           (insn),
      .insn_pc_o        (insn_pc),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .halt_req_i       (halt_req),
      .resume_i         (resume),
      .state_out_o      (state_out),
      .wrap_flag_o      (wrap_flag)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
      insn_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      halt_req = 1'b0; resume = 1'b0;
      #12;
      chk("rst_state", state_out, 2'd0);
      chk("rst_valid", insn_valid, 0);
      chk("rst_ready", load_ready, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_wrap", wrap_flag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Boot load words 0..3, last on 3.
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_addr  = 10'(i);
         load_data  = 32'hB007_0000 | 32'(i);
         load_last  = (i == 3);
         #1;
         chk("ld_ready", load_ready, 1);
         chk("ld_we", mem_we, 1);
         chk("ld_waddr", mem_waddr, 64'(i));
         chk("ld_wdata", mem_wdata, 64'h0B007_0000 | 64'(i));
         chk("ld_state", state_out, 2'd0);
         chk("ld_novalid", insn_valid, 0);
         step();
      end
      load_valid = 1'b0; load_last = 1'b0;
      insn_ready = 1'b1;
      #1;
      chk("run_state", state_out, 2'd1);
      chk("run_valid0", insn_valid, 0);
      chk("run_lready", load_ready, 0);
      chk("run_we", mem_we, 0);
      chk("run_pc0", pc_out, 0);

      // Streaming 0,1,2 then stall at 2.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("str_valid", insn_valid, 1);
         chk("str_pc", insn_pc, 64'(i));
         chk("str_insn", insn, 64'h0B007_0000 | 64'(i));
      end
      insn_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_valid", insn_valid, 1);
         chk("bp_pc", insn_pc, 2);
         chk("bp_insn", insn, 64'h0B007_0002);
         chk("bp_pcout", pc_out, 3);
      end
      insn_ready = 1'b1;
      step();
      chk("rel_pc", insn_pc, 3);
      chk("rel_insn", insn, 64'h0B007_0003);
      step();
      chk("str4_pc", insn_pc, 4);
      chk("str4_insn", insn, 64'h0C0DE_0004);

      // Redirect to 12, then redirect to 24 while 12 is presented.
      redirect_valid = 1'b1; redirect_pc = 10'd12;
      step();
      redirect_valid = 1'b0;
      chk("rd12_flush", insn_valid, 0);
      chk("rd12_pcout", pc_out, 12);
      step();
      chk("rd12_valid", insn_valid, 1);
      chk("rd12_pc", insn_pc, 12);
      redirect_valid = 1'b1; redirect_pc = 10'd24;
      step();
      redirect_valid = 1'b0;
      chk("rd24_flush", insn_valid, 0);
      chk("rd24_pcout", pc_out, 24);
      step();
      chk("rd24_valid", insn_valid, 1);
      chk("rd24_pc", insn_pc, 24);
      chk("rd24_insn", insn, 64'h0C0DE_0018);

      // Halt at pc 5, hold, halt+resume stays, then resume.
      redirect_valid = 1'b1; redirect_pc = 10'd5;
      step();
      redirect_valid = 1'b0;
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      chk("h_state", state_out, 2'd2);
      chk("h_valid", insn_valid, 0);
      chk("h_pc", pc_out, 5);
      step();
      step();
      halt_req = 1'b1; resume = 1'b1;
      step();
      halt_req = 1'b0;
      chk("h_both_state", state_out, 2'd2);
      chk("h_both_pc", pc_out, 5);
      step();
      resume = 1'b0;
      chk("res_state", state_out, 2'd1);
      chk("res_valid", insn_valid, 0);
      step();
      chk("res_pc", insn_pc, 5);
      chk("res_insn", insn, 64'h0C0DE_0005);
      chk("res_valid1", insn_valid, 1);

      // Wrap past 1023 back to 0.
      redirect_valid = 1'b1; redirect_pc = 10'd1023;
      step();
      redirect_valid = 1'b0;
      chk("wr_pre", wrap_flag, 0);
      step();
      chk("wr_pc1023", insn_pc, 1023);
      chk("wr_insn1023", insn, 64'h0C0DE_03FF);
      chk("wr_flag", wrap_flag, 1);
      chk("wr_pcout", pc_out, 0);
      step();
      chk("wr_pc0", insn_pc, 0);
      chk("wr_insn0", insn, 64'h0B007_0000);
      step();
      chk("wr_pc1", insn_pc, 1);
      chk("wr_sticky", wrap_flag, 1);

      // Asynchronous reset mid-stream, with a boot word being offered.
      #2;
      load_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("ar_state", state_out, 2'd0);
      chk("ar_valid", insn_valid, 0);
      chk("ar_insn", insn, 0);
      chk("ar_ipc", insn_pc, 0);
      chk("ar_wrap", wrap_flag, 0);
      chk("ar_pc", pc_out, 0);
      chk("ar_lready", load_ready, 0);
      chk("ar_we", mem_we, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer and owner of the 32x1024 instruction memory. After reset it accepts a program image over a boot-load handshake and writes it into the memory. It then runs a word-indexed PC, fetches one instruction per cycle into a registered output slot and hands it to decode over a valid/ready handshake. It also services branch/jump redirects, halt/resume and PC wrap reporting.

Parameters:
ADDR_W, 10, word-index width of the instruction memory (depth 2**ADDR_W)
DATA_W, 32, instruction width
RESET_PC, 0, word index fetched first after load completes or after resume-from-reset
BOOT_LOAD, 1, 1 = start in LOAD after reset; 0 = start directly in RUN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  boot word offered
load_ready  out  1  boot word accepted when load_valid&load_ready
load_addr  in  ADDR_W  target word index
load_data  in  DATA_W  instruction word
load_last  in  1  qualifies final boot word
mem_we  out  1  memory write enable
mem_waddr  out  ADDR_W  memory write index
mem_wdata  out  DATA_W  memory write data
pc_out  out  ADDR_W  memory read index (combinational read, data same cycle)
mem_rdata  in  DATA_W  memory read data
insn_valid  out  1  insn/insn_pc hold a fetched instruction
insn_ready  in  1  decode accepts when insn_valid&insn_ready
insn  out  DATA_W  fetched instruction
insn_pc  out  ADDR_W  index insn was fetched from
redirect_valid  in  1  taken branch/jal/jalr, one-cycle pulse
redirect_pc  in  ADDR_W  redirect target word index
halt_req  in  1  stop fetching
resume  in  1  leave HALT
state_out  out  2  LOAD=0, RUN=1, HALT=2
wrap_flag  out  1  sticky: PC incremented past 2**ADDR_W-1

Behaviour:
- Reset (async, rst_n=0): state=LOAD (or RUN if BOOT_LOAD=0); pc=RESET_PC; insn_valid=0; insn=0; insn_pc=0; wrap_flag=0; mem_we=0; load_ready=0. Reset mid-load or mid-run abandons everything; memory contents are not cleared.
- LOAD: load_ready=1 combinationally. Each accepted word drives mem_we=1, mem_waddr=load_addr, mem_wdata=load_data in the same cycle (write lands at that edge). No fetch; insn_valid=0; pc_out=pc. Accepted word with load_last=1 -> RUN next cycle, pc=RESET_PC. redirect/halt_req/resume ignored.
- RUN: load_ready=0, mem_we=0. pc_out=pc. Fetch enable fe = !insn_valid | insn_ready.
  - redirect_valid (highest priority): pc<=redirect_pc, insn_valid<=0 (in-flight slot flushed even if accepted this cycle); first redirected instruction valid 2 cycles after the pulse.
  - else halt_req: ->HALT, insn_valid<=0, pc holds (next to fetch).
  - else fe: insn<=mem_rdata, insn_pc<=pc, insn_valid<=1, pc<=pc+1 mod 2**ADDR_W; if pc==2**ADDR_W-1, wrap_flag<=1.
  - else stall: all registers hold; insn/insn_pc stable while insn_valid&!insn_ready.
  - Throughput 1 insn/cycle with insn_ready tied high; first insn valid 1 cycle after entering RUN.
- HALT: insn_valid=0, no fetch, pc holds. resume -> RUN next cycle, fetch continues from held pc. redirect_valid in HALT updates pc only. halt_req and resume together: stay HALT.
- state_out reflects the registered state; wrap_flag is cleared only by reset.

Decomposition:
- Package fetch_pkg: state encoding constants (ST_LOAD, ST_RUN, ST_HALT), ADDR_W/DATA_W defaults, RESET_PC.
- One sub-module is natural: fetch_slot (one-entry output register with valid/ready, flush and load inputs). The FSM and PC stay in fetch_ctrl.

Test Plan:
- Boot load: 4 words to addr 0..3, last on addr 3 -> 4 mem_we pulses with matching addr/data; state_out 0->1 the cycle after the last accept; insn_pc=0 valid one cycle later.
- Streaming: insn_ready=1 -> insn_pc 0,1,2,3 on consecutive cycles with insn=mem[idx].
- Backpressure: insn_ready=0 for 3 cycles at insn_pc=2 -> insn/insn_pc frozen, pc_out=3 held; release -> insn_pc 3 next cycle.
- Redirect: pulse redirect_pc=24 while insn_pc=12 valid -> insn_valid=0 next cycle, then insn_pc=24; 13 never presented.
- Halt/resume: halt_req at pc=5 -> state 2, insn_valid=0; resume 4 cycles later -> state 1, next insn_pc=5.
- Wrap and reset: redirect to 1023, stream -> insn_pc 1023 then 0, wrap_flag=1. rst_n low mid-stream -> state 0, outputs at reset values immediately.
